dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-master arbiter for the single data-memory port of the MIPS system. It sits between the CPU data port (requester 0) and a secondary bus master such as a DMA or debug loader (requester 1) on one side, and the `m_data_*` memory interface on the other. It grants at most one transaction per cycle, using round-robin priority with an optional bounded lock. It also returns read data with fixed one-cycle latency.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grants one requester may take under lock while the other requester is waiting (legal range 1–15).
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `r0_req` in 1: CPU requests a transaction this cycle.
- `r0_lock` in 1: CPU asks to keep ownership after this grant.
- `r0_addr` in 32: CPU byte address.
- `r0_wdata` in 32: CPU write data.
- `r0_byteen` in 4: CPU byte enables; 0 means read.
- `r0_gnt` out 1: CPU transaction accepted this cycle.
- `r0_rdata` out 32: read data for CPU.
- `r0_rvalid` out 1: `r0_rdata` valid.
- `r1_req`, `r1_lock`, `r1_addr`, `r1_wdata`, `r1_byteen`, `r1_gnt`, `r1_rdata`, `r1_rvalid`: same widths and meaning, for requester 1.
- `m_data_addr` out 32: memory address, forced word-aligned (bits [1:0] = 0).
- `m_data_wdata` out 32: memory write data.
- `m_data_byteen` out 4: memory byte enables; must be 0 when no write is granted.
- `m_data_rdata` in 32: memory read data, combinational from `m_data_addr`.

## Operation
- State: `owner` ∈ {NONE, R0, R1}, `last` (1 bit, last granted requester), `hold` (4-bit counter), plus the read-return registers.
- Grant is combinational within the cycle:
  - If `owner` = Rx and `rx_req` = 1, Rx is granted, unless the other requester is requesting and `hold` = `MAX_HOLD`. In that case the other requester is granted.
  - Otherwise, with one requester active, that requester is granted.
  - Otherwise, with both active, the requester ≠ `last` is granted (round-robin).
  - With no requests, nothing is granted.
- Memory drive:
  - The granted requester's addr/wdata/byteen pass to `m_data_*`.
  - With no grant: `m_data_addr` = 0, `m_data_wdata` = 0, `m_data_byteen` = 0.
- On the clock edge with grant to Rx:
  - `last` <= x.
  - If `rx_lock` = 1: `owner` <= Rx.
  - Otherwise: `owner` <= NONE.
  - `hold` <= `hold`+1 if this is the same owner continuing under lock; 1 if the grant started fresh.
  - Counter saturates at 15.
- Edge with no grant: `owner` <= NONE, `hold` <= 0.
- Owner Rx deasserting `rx_req` releases the lock immediately in the same cycle; the other requester may be granted.
- Read (granted, byteen = 0):
  - `m_data_rdata` is captured into `rx_rdata` at the grant edge.
  - `rx_rvalid` = 1 for exactly the next cycle.
- Write (granted, byteen ≠ 0): memory commits at the grant edge; `rx_rvalid` stays 0.
- `rx_rdata` holds its last value when `rx_rvalid` = 0.

## Timing
- Reset values (`reset` = 0 at an edge):
  - `owner` = NONE, `last` = R1 (so R0 wins the first tie), `hold` = 0.
  - `r0_rvalid` = `r1_rvalid` = 0; `r0_rdata` = `r1_rdata` = 0.
- While `reset` = 0: all grants forced to 0 and `m_data_byteen` = 0, even if requests are high.
- A reset arriving mid-lock or mid-read drops ownership; a pending `rvalid` is suppressed.
- Grant latency: 0 cycles (same cycle as `req`) when uncontested.
- Read latency: 1 cycle from grant to `rvalid`.
- Throughput: one transaction per cycle, back-to-back allowed for either requester.
- A requester must hold req/addr/wdata/byteen stable until it sees `gnt`=1.
- Fairness: a waiting requester is granted within `MAX_HOLD`+1 cycles of asserting `req`.
- Simultaneous events:
  - Lock release and contention in the same cycle follow round-robin via `last`.
  - A `rvalid` for Rx and a new grant to Rx may coincide.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with both req=1 → both gnt=0, byteen=0 throughout. First edge after release: r0_gnt=1 (`last`=R1 tie-break).
- Round-robin: both req, no lock, for 4 cycles → grants alternate R0,R1,R0,R1, with `m_data_addr` following each requester's addr.
- Read return: R1 reads addr 0x0000_0008 with memory word 0xDEAD_BEEF → r1_gnt cycle n; r1_rvalid=1, r1_rdata=0xDEAD_BEEF in cycle n+1 only; r0_rvalid stays 0.
- Bounded lock: `MAX_HOLD`=4, R0 req+lock continuously, R1 req from cycle 0 → R0 granted cycles 0–3, R1 granted cycle 4; R1 write byteen=0xF, wdata=0x1234_5678 appears on `m_data_*` that cycle.
- Address alignment and idle: R0 write addr 0x0000_0013, byteen=4'b0010 → `m_data_addr`=0x0000_0010, byteen=4'b0010. Next cycle with no req → `m_data_byteen`=0, `m_data_addr`=0.
- Reset mid-read: grant R0 read, assert `reset`=0 at the next edge → r0_rvalid remains 0; `owner`=NONE after release.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master round-robin arbiter for the data-memory port.
// The owner may hold the port under lock for up to MAX_HOLD grants while the other requester waits.
module dm_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        r0_req_i,
  input  logic        r0_lock_i,
  input  logic [31:0] r0_addr_i,
  input  logic [31:0] r0_wdata_i,
  input  logic [3:0]  r0_byteen_i,
  output logic        r0_gnt_o,
  output logic [31:0] r0_rdata_o,
  output logic        r0_rvalid_o,
  input  logic        r1_req_i,
  input  logic        r1_lock_i,
  input  logic [31:0] r1_addr_i,
  input  logic [31:0] r1_wdata_i,
  input  logic [3:0]  r1_byteen_i,
  output logic        r1_gnt_o,
  output logic [31:0] r1_rdata_o,
  output logic        r1_rvalid_o,
  output logic [31:0] m_data_addr_o,
  output logic [31:0] m_data_wdata_o,
  output logic [3:0]  m_data_byteen_o,
  input  logic [31:0] m_data_rdata_i
);
  typedef enum logic [1:0] {NONE, R0, R1} owner_e;
  owner_e      owner_q, owner_d;
  logic        last_q, last_d;
  logic [3:0]  hold_q, hold_d;
  logic        rv0_q, rv0_d, rv1_q, rv1_d;
  logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic        own0, own1, at_max, g0, g1, cont;
  assign own0   = owner_q == R0 && r0_req_i;
  assign own1   = owner_q == R1 && r1_req_i;
  assign at_max = hold_q == 4'(MAX_HOLD);
  // A live lock wins unless the other side waits and the hold budget is spent.
  assign g0 = reset_ni && (own0 ? !(r1_req_i && at_max) :
                           own1 ? (r0_req_i && at_max) :
                           r0_req_i && (!r1_req_i || last_q));
  assign g1 = reset_ni && (own1 ? !(r0_req_i && at_max) :
                           own0 ? (r1_req_i && at_max) :
                           r1_req_i && (!r0_req_i || !last_q));
  assign r0_gnt_o        = g0;
  assign r1_gnt_o        = g1;
  assign m_data_addr_o   = g0 ? {r0_addr_i[31:2], 2'b00} : g1 ? {r1_addr_i[31:2], 2'b00} : 32'h0;
  assign m_data_wdata_o  = g0 ? r0_wdata_i : g1 ? r1_wdata_i : 32'h0;
  assign m_data_byteen_o = g0 ? r0_byteen_i : g1 ? r1_byteen_i : 4'h0;
  assign cont    = (g0 && owner_q == R0) || (g1 && owner_q == R1);
  assign last_d  = g0 ? 1'b0 : g1 ? 1'b1 : last_q;
  assign owner_d = (g0 && r0_lock_i) ? R0 : (g1 && r1_lock_i) ? R1 : NONE;
  assign hold_d  = !(g0 || g1) ? 4'd0 : !cont ? 4'd1 : (hold_q == 4'hF) ? 4'hF : hold_q + 4'd1;
  assign rv0_d   = g0 && r0_byteen_i == 4'h0;
  assign rv1_d   = g1 && r1_byteen_i == 4'h0;
  assign rd0_d   = rv0_d ? m_data_rdata_i : rd0_q;
  assign rd1_d   = rv1_d ? m_data_rdata_i : rd1_q;
  // Reset also masks a read return already in flight.
  assign r0_rvalid_o = rv0_q && reset_ni;
  assign r1_rvalid_o = rv1_q && reset_ni;
  assign r0_rdata_o  = rd0_q;
  assign r1_rdata_o  = rd1_q;
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      owner_q <= NONE;
      last_q  <= 1'b1;
      hold_q  <= 4'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= 32'h0;
      rd1_q   <= 32'h0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed plus random stimulus against a queue-based reference model;
// a negedge monitor pops expected grants/read returns and compares.
module tb_dm_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_ni = 1'b0;
  logic        r0_req_i = 0, r0_lock_i = 0, r1_req_i = 0, r1_lock_i = 0;
  logic [31:0] r0_addr_i = 0, r0_wdata_i = 0, r1_addr_i = 0, r1_wdata_i = 0;
  logic [3:0]  r0_byteen_i = 0, r1_byteen_i = 0;
  logic        r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o;
  logic [31:0] r0_rdata_o, r1_rdata_o, m_data_addr_o, m_data_wdata_o, m_data_rdata_i;
  logic [3:0]  m_data_byteen_o;
  logic [31:0] mem [16];
  assign m_data_rdata_i = mem[m_data_addr_o[5:2]];
  dm_arbiter #(.MAX_HOLD(MH)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .r0_req_i(r0_req_i), .r0_lock_i(r0_lock_i), .r0_addr_i(r0_addr_i), .r0_wdata_i(r0_wdata_i),
    .r0_byteen_i(r0_byteen_i), .r0_gnt_o(r0_gnt_o), .r0_rdata_o(r0_rdata_o), .r0_rvalid_o(r0_rvalid_o),
    .r1_req_i(r1_req_i), .r1_lock_i(r1_lock_i), .r1_addr_i(r1_addr_i), .r1_wdata_i(r1_wdata_i),
    .r1_byteen_i(r1_byteen_i), .r1_gnt_o(r1_gnt_o), .r1_rdata_o(r1_rdata_o), .r1_rvalid_o(r1_rvalid_o),
    .m_data_addr_o(m_data_addr_o), .m_data_wdata_o(m_data_wdata_o),
    .m_data_byteen_o(m_data_byteen_o), .m_data_rdata_i(m_data_rdata_i)
  );
  typedef struct {int cyc; logic g0; logic g1; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} gexp_t;
  typedef struct {int cyc; int who; logic [31:0] data;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  int n_assert = 0, n_fail = 0, cyc = 0;
  int m_owner = -1, m_last = 1, m_hold = 0, g_cur = -1;
  logic [31:0] last_rd [2];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", n, cyc, act, exp);
    end
  endtask
  function automatic int mgrant();
    bit q [2];
    q[0] = r0_req_i;
    q[1] = r1_req_i;
    if (!reset_ni) return -1;
    if (m_owner >= 0 && q[m_owner]) return (q[1-m_owner] && m_hold == MH) ? 1 - m_owner : m_owner;
    if (q[0] && q[1]) return 1 - m_last;
    if (q[0]) return 0;
    if (q[1]) return 1;
    return -1;
  endfunction
  task automatic commit();
    logic [31:0] a, w;
    logic [3:0]  b;
    logic        l;
    a = g_cur == 1 ? r1_addr_i : r0_addr_i;
    w = g_cur == 1 ? r1_wdata_i : r0_wdata_i;
    b = g_cur == 1 ? r1_byteen_i : r0_byteen_i;
    l = g_cur == 1 ? r1_lock_i : r0_lock_i;
    if (!reset_ni) begin
      m_owner = -1; m_last = 1; m_hold = 0;
      last_rd[0] = 0; last_rd[1] = 0;
    end else if (g_cur >= 0) begin
      for (int i = 0; i < 4; i++) if (b[i]) mem[a[5:2]][8*i +: 8] = w[8*i +: 8];
      m_hold  = (m_owner == g_cur) ? (m_hold < 15 ? m_hold + 1 : 15) : 1;
      m_owner = l ? g_cur : -1;
      m_last  = g_cur;
    end else begin
      m_owner = -1; m_hold = 0;
    end
  endtask
  task automatic drive(input logic rst, input logic q0, input logic l0, input logic [31:0] a0,
                       input logic [31:0] w0, input logic [3:0] b0, input logic q1, input logic l1,
                       input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] b1);
    gexp_t e;
    @(posedge clk);
    commit();
    cyc++;
    #1;
    reset_ni = rst;
    r0_req_i = q0; r0_lock_i = l0; r0_addr_i = a0; r0_wdata_i = w0; r0_byteen_i = b0;
    r1_req_i = q1; r1_lock_i = l1; r1_addr_i = a1; r1_wdata_i = w1; r1_byteen_i = b1;
    g_cur = mgrant();
    e.cyc = cyc; e.g0 = g_cur == 0; e.g1 = g_cur == 1;
    e.addr  = g_cur < 0 ? 32'h0 : (g_cur == 1 ? a1 : a0) & 32'hFFFF_FFFC;
    e.wdata = g_cur < 0 ? 32'h0 : (g_cur == 1 ? w1 : w0);
    e.be    = g_cur < 0 ? 4'h0 : (g_cur == 1 ? b1 : b0);
    gq.push_back(e);
    if (g_cur >= 0 && e.be == 4'h0) rq.push_back('{cyc, g_cur, mem[e.addr[5:2]]});
  endtask
  task automatic idle(input logic rst);
    drive(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  gexp_t me;
  rexp_t mr;
  logic  ev0, ev1;
  always @(negedge clk) begin
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      me = gq.pop_front();
      chk("gnt", {30'h0, r0_gnt_o, r1_gnt_o}, {30'h0, me.g0, me.g1});
      chk("m_addr", m_data_addr_o, me.addr);
      chk("m_wdata", m_data_wdata_o, me.wdata);
      chk("m_byteen", {28'h0, m_data_byteen_o}, {28'h0, me.be});
    end
    if (cyc >= 1) begin
      ev0 = rq.size() > 0 && rq[0].cyc == cyc - 1 && rq[0].who == 0;
      ev1 = rq.size() > 0 && rq[0].cyc == cyc - 1 && rq[0].who == 1;
      if (ev0 || ev1) begin
        mr = rq.pop_front();
        last_rd[mr.who] = mr.data;
      end
      chk("rvalid", {30'h0, r0_rvalid_o, r1_rvalid_o}, {30'h0, ev0 && reset_ni, ev1 && reset_ni});
      chk("rdata0", r0_rdata_o, last_rd[0]);
      chk("rdata1", r1_rdata_o, last_rd[1]);
    end
  end
  bit          pq [2], pl [2];
  logic [31:0] pa [2], pw [2];
  logic [3:0]  pb [2];
  bit          r1_done;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[2] = 32'hDEAD_BEEF;
    last_rd[0] = 0; last_rd[1] = 0;
    for (int k = 0; k < 3; k++) drive(0, 1, 0, 32'h100, 0, 0, 1, 0, 32'h204, 0, 0);
    for (int k = 0; k < 5; k++) drive(1, 1, 0, 32'h100, 0, 0, 1, 0, 32'h204, 0, 0);
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 32'h8, 0, 0);
    idle(1);
    idle(1);
    r1_done = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 1, 32'h40, 0, 0, !r1_done, 0, 32'h44, 32'h1234_5678, 4'hF);
      if (g_cur == 1) r1_done = 1;
    end
    idle(1);
    drive(1, 1, 0, 32'h13, 32'hA5A5_5A5A, 4'b0010, 0, 0, 0, 0, 0);
    idle(1);
    drive(1, 1, 0, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 0);
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pq[i] && $urandom_range(9) < 7) begin
          pq[i] = 1;
          pl[i] = ($urandom_range(3) != 0);
          pa[i] = $urandom;
          pw[i] = $urandom;
          pb[i] = $urandom_range(1) ? 4'($urandom_range(14) + 1) : 4'h0;
        end
      drive($urandom_range(49) != 0, pq[0], pl[0], pa[0], pw[0], pb[0], pq[1], pl[1], pa[1], pw[1], pb[1]);
      if (g_cur >= 0) pq[g_cur] = 0;
    end
    idle(1);
    idle(1);
    @(negedge clk);
    @(negedge clk);
    chk("drain", rq.size() + gq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
